// File: rtl/clk_period_meter.sv
// clk_period_meter
// Measures the period and high time of a slow clock (typically a divider
// output) in units of I_CLK cycles, averaged over 2**AVG_LOG2 periods.
// A watchdog aborts the measurement if no rising edge arrives within
// TIMEOUT cycles, so a dead input cannot leave the block busy forever.

module clk_period_meter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned TIMEOUT     = 1000000
) (
    input  logic        I_CLK,
    input  logic        Rst,
    input  logic        SIG_IN,
    input  logic        Start,
    output logic [31:0] Period,
    output logic [31:0] High_T,
    output logic        Valid,
    output logic        Timeout,
    output logic        Busy
);

    // Number of rising edges that close one averaged measurement.
    localparam int unsigned AVG_N     = 32'd1 << AVG_LOG2;
    localparam logic [8:0]  AVG_N_W   = 9'(AVG_N);
    // Last watchdog value tolerated before the measurement is aborted.
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                  state_r;
    logic [SYNC_STAGES-1:0]  sync_r;
    logic                    s_d_r;
    logic [8:0]              edge_cnt_r;
    logic [31:0]             total_r;
    logic [31:0]             high_r;
    logic [31:0]             wdog_r;

    logic                    s_s;
    logic                    rise_s;
    logic                    last_rise_s;
    logic                    wdog_exp_s;
    logic [31:0]             total_inc_s;
    logic [31:0]             high_inc_s;
    logic [31:0]             wdog_inc_s;
    logic [8:0]              edge_inc_s;

    // Averaging is a plain truncating divide by the power-of-two window.
    function automatic logic [31:0] avg_shift(input logic [31:0] value);
        return value >> AVG_LOG2;
    endfunction

    // Bring the asynchronous input into the I_CLK domain and keep one
    // delayed copy for rising-edge detection.
    always_ff @(posedge I_CLK or posedge Rst) begin
        if (Rst) begin
            sync_r <= '0;
            s_d_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], SIG_IN};
            s_d_r  <= sync_r[SYNC_STAGES-1];
        end
    end

    // Edge detect and the next-value arithmetic shared by the FSM.
    always_comb begin
        s_s         = sync_r[SYNC_STAGES-1];
        rise_s      = s_s & ~s_d_r;
        total_inc_s = total_r + 32'd1;
        high_inc_s  = high_r + {31'd0, s_s};
        wdog_inc_s  = wdog_r + 32'd1;
        edge_inc_s  = edge_cnt_r + 9'd1;
        wdog_exp_s  = (wdog_r == WDOG_LAST);
        if (rise_s && (edge_inc_s == AVG_N_W)) begin
            last_rise_s = 1'b1;
        end else begin
            last_rise_s = 1'b0;
        end
    end

    // Measurement sequencer; all outputs are registered here.
    always_ff @(posedge I_CLK or posedge Rst) begin
        if (Rst) begin
            state_r    <= ST_IDLE;
            edge_cnt_r <= 9'd0;
            total_r    <= 32'd0;
            high_r     <= 32'd0;
            wdog_r     <= 32'd0;
            Period     <= 32'd0;
            High_T     <= 32'd0;
            Valid      <= 1'b0;
            Timeout    <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        state_r    <= ST_ARM;
                        edge_cnt_r <= 9'd0;
                        total_r    <= 32'd0;
                        high_r     <= 32'd0;
                        wdog_r     <= 32'd0;
                        Valid      <= 1'b0;
                        Timeout    <= 1'b0;
                        Busy       <= 1'b1;
                    end else begin
                        state_r <= state_r;
                        Busy    <= 1'b0;
                    end
                end

                ST_ARM: begin
                    if (rise_s) begin
                        // This cycle is t0: the counting window opens here.
                        state_r <= ST_MEASURE;
                        total_r <= 32'd0;
                        high_r  <= 32'd0;
                        wdog_r  <= 32'd0;
                        Busy    <= 1'b1;
                    end else if (wdog_exp_s) begin
                        state_r <= ST_DONE;
                        Timeout <= 1'b1;
                        Valid   <= 1'b0;
                        Busy    <= 1'b0;
                    end else begin
                        wdog_r <= wdog_inc_s;
                        Busy   <= 1'b1;
                    end
                end

                ST_MEASURE: begin
                    total_r <= total_inc_s;
                    high_r  <= high_inc_s;
                    if (last_rise_s) begin
                        // The closing edge's own increments are part of the window.
                        state_r    <= ST_DONE;
                        edge_cnt_r <= edge_inc_s;
                        wdog_r     <= 32'd0;
                        Period     <= avg_shift(total_inc_s);
                        High_T     <= avg_shift(high_inc_s);
                        Valid      <= 1'b1;
                        Busy       <= 1'b0;
                    end else if (rise_s) begin
                        edge_cnt_r <= edge_inc_s;
                        wdog_r     <= 32'd0;
                        Busy       <= 1'b1;
                    end else if (wdog_exp_s) begin
                        state_r <= ST_DONE;
                        Timeout <= 1'b1;
                        Valid   <= 1'b0;
                        Busy    <= 1'b0;
                    end else begin
                        wdog_r <= wdog_inc_s;
                        Busy   <= 1'b1;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

    clk_period_meter_chk u_chk (
        .I_CLK   (I_CLK),
        .Rst     (Rst),
        .Valid   (Valid),
        .Timeout (Timeout),
        .Busy    (Busy)
    );

endmodule

// clk_period_meter_chk
// Output consistency properties for clk_period_meter.

module clk_period_meter_chk (
    input logic I_CLK,
    input logic Rst,
    input logic Valid,
    input logic Timeout,
    input logic Busy
);

    // A measurement ends either with a result or with a timeout, never both.
    a_valid_xor_timeout: assert property (
        @(posedge I_CLK) disable iff (Rst) !(Valid && Timeout)
    );

    // While busy, the status of the previous measurement has been cleared.
    a_busy_clears_status: assert property (
        @(posedge I_CLK) disable iff (Rst) Busy |-> (!Valid && !Timeout)
    );

endmodule
